dispatch_team_scheduler: RTL

- Sequences the Serve side of the relief-request queues against a finite pool of field teams.
- Watches the already-arbitrated queue head (Evac-first, then Shelter/Food) and issues a single-cycle serve pulse only when a team is free.
- Binds the popped request to the lowest-index free team and runs a per-team mission down-counter; the team returns to the pool when the counter expires.
- Sits between the queue top level and the dispatch/status outputs.

---
 rtl/dispatch_team_scheduler_pkg.sv | 41 ++++
 rtl/dispatch_team_scheduler_if.sv | 41 ++++
 rtl/dispatch_team_scheduler_team_timer.sv | 67 ++++++
 rtl/dispatch_team_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_team_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// resq_pkg
// Shared types and constants for the relief dispatch team scheduler:
//   - serve sequencer state encoding (IDLE -> ISSUE -> SETTLE)
//   - team index, zone, priority and counter widths
//   - default mission lengths for Shelter/Food and Evac requests
//   - lowest_set(): index of the lowest set bit of a team mask
// Optional feature macro used by the design: RESERVE_EVAC_TEAM_EN
// -----------------------------------------------------------------------------
package resq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int TEAM_IDX_W = 3;
  localparam int MAX_TEAMS  = 8;
  localparam int ZONE_W     = 8;
  localparam int PRIO_W     = 2;
  localparam int COUNT_W    = 16;

  localparam logic [7:0] DEF_MISSION_CYCLES = 8'd20;
  localparam logic [7:0] DEF_EVAC_CYCLES    = 8'd40;

  // Scanning from the top down leaves the lowest set index in idx.
  function automatic logic [TEAM_IDX_W-1:0] lowest_set(input logic [MAX_TEAMS-1:0] mask);
    logic [TEAM_IDX_W-1:0] idx;
    idx = 3'd0;
    for (int i = MAX_TEAMS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = TEAM_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dispatch_team_scheduler_if.sv
// -----------------------------------------------------------------------------
// dispatch_team_scheduler_if
// Bundles the queue-head inputs and the dispatch/status outputs of the team
// scheduler.
//   master : drives head_valid/head_evac/head_zone/head_priority, observes
//            serve_out and the dispatch/status outputs (queue side / bench)
//   slave  : the scheduler itself
// Parameter NUM_TEAMS sizes busy_mask and done_mask.
// -----------------------------------------------------------------------------
interface dispatch_team_scheduler_if #(
  parameter int NUM_TEAMS = 4
);
  import resq_pkg::*;

  logic                  head_valid;
  logic                  head_evac;
  logic [ZONE_W-1:0]     head_zone;
  logic [PRIO_W-1:0]     head_priority;
  logic                  serve_out;
  logic                  dispatch_valid;
  logic [TEAM_IDX_W-1:0] dispatch_team;
  logic [ZONE_W-1:0]     dispatch_zone;
  logic [PRIO_W-1:0]     dispatch_priority;
  logic [NUM_TEAMS-1:0]  busy_mask;
  logic                  all_busy;
  logic [NUM_TEAMS-1:0]  done_mask;
  logic [COUNT_W-1:0]    dispatch_count;

  modport master (
    output head_valid, head_evac, head_zone, head_priority,
    input  serve_out, dispatch_valid, dispatch_team, dispatch_zone,
           dispatch_priority, busy_mask, all_busy, done_mask, dispatch_count
  );

  modport slave (
    input  head_valid, head_evac, head_zone, head_priority,
    output serve_out, dispatch_valid, dispatch_team, dispatch_zone,
           dispatch_priority, busy_mask, all_busy, done_mask, dispatch_count
  );

endinterface

// File: rtl/dispatch_team_scheduler_team_timer.sv
// -----------------------------------------------------------------------------
// team_timer
// Mission down-counter for a single field team.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a mission this edge (only asserted while idle)
//   load_val   : mission length in cycles (>= 1)
//   busy       : registered, high while the mission runs
//   busy_next  : value busy takes at the next edge
//   done       : registered one-cycle pulse on the 1 -> 0 transition
// -----------------------------------------------------------------------------
module team_timer
  import resq_pkg::*;
#(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               busy,
  output logic               busy_next,
  output logic               done
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Counter next state: load, decrement while busy, and flag expiry
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      count_d = count_q - TIMER_W'(1);
      if (count_q == TIMER_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter state registers; reset aborts a mission without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {TIMER_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign busy_next = busy_d;
  assign done      = done_q;

endmodule

// File: rtl/dispatch_team_scheduler.sv
// -----------------------------------------------------------------------------
// dispatch_team_scheduler
// Serves the arbitrated relief-queue head against a pool of NUM_TEAMS field
// teams. When the head is valid and an eligible team is free, it pops the head
// (one-cycle serve_out), binds the request to the lowest-index eligible free
// team and runs that team's mission timer; the team returns to the pool when
// the timer expires. A SETTLE cycle after each pop lets the queue heads update.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dispatch_team_scheduler_if.slave
//                in : head_valid, head_evac, head_zone, head_priority
//                out: serve_out, dispatch_valid, dispatch_team, dispatch_zone,
//                     dispatch_priority, busy_mask, all_busy, done_mask,
//                     dispatch_count
// Optional feature: define RESERVE_EVAC_TEAM_EN to reserve team 0 for Evac.
// -----------------------------------------------------------------------------
module dispatch_team_scheduler
  import resq_pkg::*;
#(
  parameter int                 NUM_TEAMS      = 4,
  parameter int                 TIMER_W        = 8,
  parameter logic [TIMER_W-1:0] MISSION_CYCLES = TIMER_W'(DEF_MISSION_CYCLES),
  parameter logic [TIMER_W-1:0] EVAC_CYCLES    = TIMER_W'(DEF_EVAC_CYCLES)
) (
  input logic                      clk,
  input logic                      rst_n,
  dispatch_team_scheduler_if.slave bus
);

  state_e                state_q, state_d;
  logic                  serve_q, serve_d;
  logic                  dv_q, dv_d;
  logic [TEAM_IDX_W-1:0] team_q, team_d;
  logic [ZONE_W-1:0]     zone_q, zone_d;
  logic [PRIO_W-1:0]     prio_q, prio_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  all_busy_q, all_busy_d;

  logic                  issue_s;
  logic [TIMER_W-1:0]    load_val_s;
  logic [NUM_TEAMS-1:0]  load_vec_s;
  logic [NUM_TEAMS-1:0]  elig_mask_s;
  logic [NUM_TEAMS-1:0]  free_elig_s;
  logic [MAX_TEAMS-1:0]  free_pad_s;
  logic [NUM_TEAMS-1:0]  busy_vec_s;
  logic [NUM_TEAMS-1:0]  busy_next_s;
  logic [NUM_TEAMS-1:0]  done_vec_s;

  // Teams that may take the current head request
  always_comb begin
    elig_mask_s = {NUM_TEAMS{1'b1}};
`ifdef RESERVE_EVAC_TEAM_EN
    // Team 0 is held back for Evac heads only.
    if (bus.head_evac) begin
      elig_mask_s = {NUM_TEAMS{1'b1}};
    end else begin
      elig_mask_s[0] = 1'b0;
    end
`endif
  end

  // Free eligible teams; busy_vec_s is the registered busy bit, so a team
  // freed on this edge is only offered from the next edge onward.
  always_comb begin
    free_elig_s = ~busy_vec_s & elig_mask_s;
    free_pad_s  = {MAX_TEAMS{1'b0}};
    free_pad_s[NUM_TEAMS-1:0] = free_elig_s;
  end

  // Sequencer next state; serve/dispatch outputs are set on the IDLE->ISSUE
  // edge so they are visible, registered, throughout the ISSUE cycle.
  always_comb begin
    state_d    = state_q;
    serve_d    = 1'b0;
    dv_d       = 1'b0;
    team_d     = team_q;
    zone_d     = zone_q;
    prio_d     = prio_q;
    count_d    = count_q;
    issue_s    = 1'b0;
    load_val_s = MISSION_CYCLES;
    case (state_q)
      ST_IDLE: begin
        if (bus.head_valid && (|free_elig_s)) begin
          state_d = ST_ISSUE;
          serve_d = 1'b1;
          dv_d    = 1'b1;
          issue_s = 1'b1;
          team_d  = lowest_set(free_pad_s);
          zone_d  = bus.head_zone;
          prio_d  = bus.head_priority;
          if (bus.head_evac) begin
            load_val_s = EVAC_CYCLES;
          end else begin
            load_val_s = MISSION_CYCLES;
          end
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // One-hot timer load for the chosen team
  always_comb begin
    load_vec_s = {NUM_TEAMS{1'b0}};
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (issue_s && (team_d == TEAM_IDX_W'(i))) begin
        load_vec_s[i] = 1'b1;
      end else begin
        load_vec_s[i] = 1'b0;
      end
    end
  end

  // all_busy follows the busy bits that will be visible next cycle, so it
  // lines up with busy_mask; ineligible teams are masked out.
  always_comb begin
    all_busy_d = &(busy_next_s | ~elig_mask_s);
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      serve_q    <= 1'b0;
      dv_q       <= 1'b0;
      team_q     <= 3'd0;
      zone_q     <= 8'd0;
      prio_q     <= 2'd0;
      count_q    <= 16'd0;
      all_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      serve_q    <= serve_d;
      dv_q       <= dv_d;
      team_q     <= team_d;
      zone_q     <= zone_d;
      prio_q     <= prio_d;
      count_q    <= count_d;
      all_busy_q <= all_busy_d;
    end
  end

  for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_team
    team_timer #(
      .TIMER_W (TIMER_W)
    ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec_s[g]),
      .load_val  (load_val_s),
      .busy      (busy_vec_s[g]),
      .busy_next (busy_next_s[g]),
      .done      (done_vec_s[g])
    );
  end

  assign bus.serve_out         = serve_q;
  assign bus.dispatch_valid    = dv_q;
  assign bus.dispatch_team     = team_q;
  assign bus.dispatch_zone     = zone_q;
  assign bus.dispatch_priority = prio_q;
  assign bus.busy_mask         = busy_vec_s;
  assign bus.all_busy          = all_busy_q;
  assign bus.done_mask         = done_vec_s;
  assign bus.dispatch_count    = count_q;

endmodule
